// File: rtl/ysyx_22050039_mem_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM state encoding and
// requester (owner) identifiers.
package ysyx_22050039_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_IFU) ? OWN_LSU : OWN_IFU;
  endfunction

endpackage

// File: rtl/ysyx_22050039_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to the requester that did not win last time.
module ysyx_22050039_rr_pick
  import ysyx_22050039_mem_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  owner_e pick;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick = OWN_IFU;
    if (ifu_valid && lsu_valid) begin
      pick = other_owner(owner_e'(last_grant));
    end else if (lsu_valid) begin
      pick = OWN_LSU;
    end
  end

  assign grant_valid = ifu_valid | lsu_valid;
  assign grant_id    = pick;

endmodule

// File: rtl/ysyx_22050039_mem_arbiter.sv
// Shares the single memory port between IFU and LSU: round-robin grant, one
// outstanding transaction, response routed back to the latched owner.
module ysyx_22050039_mem_arbiter
  import ysyx_22050039_mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  // IFU (read-only)
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [XLEN-1:0]   ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [XLEN-1:0]   ifu_rdata,
  // LSU
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic              lsu_wen,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic [XLEN-1:0]   lsu_rdata,
  // memory port
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  // status
  output logic              busy,
  output logic              err
);

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic              wen;
    logic [XLEN-1:0]   wdata;
    logic [MASK_W-1:0] wmask;
    owner_e            owner;
  } payload_t;

  state_e   state_q, state_d;
  owner_e   last_grant_q, last_grant_d;
  payload_t pl_q, pl_d;
  logic     err_q, err_d;

  logic     grant_valid;
  logic     grant_id_raw;
  owner_e   grant_id;
  logic     grant_take;
  logic     rsp_route;

  ysyx_22050039_rr_pick u_rr_pick (
    .ifu_valid   (ifu_req_valid),
    .lsu_valid   (lsu_req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id_raw)
  );

  assign grant_id = owner_e'(grant_id_raw);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pl_d         = pl_q;
    grant_take   = 1'b0;
    // A response outside WAIT_RSP has no owner; it is dropped and flagged.
    err_d        = err_q | (mem_rsp_valid && (state_q != ST_WAIT_RSP));

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          grant_take   = 1'b1;
          state_d      = ST_REQ;
          last_grant_d = grant_id;
          pl_d.owner   = grant_id;
          if (grant_id == OWN_IFU) begin
            pl_d.addr  = ifu_addr;
            pl_d.wen   = 1'b0;
            pl_d.wdata = '0;
            pl_d.wmask = '0;
          end else begin
            pl_d.addr  = lsu_addr;
            pl_d.wen   = lsu_wen;
            pl_d.wdata = lsu_wdata;
            pl_d.wmask = lsu_wmask;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (mem_rsp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_LSU;
      // NOTE: the payload registers are reset too, so mem_* never shows X
      // and a dropped transaction leaves nothing behind.
      pl_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pl_q         <= pl_d;
      err_q        <= err_d;
    end
  end

  // Ready is gated by rst so a requester is never told "accepted" in reset.
  assign ifu_req_ready = rst && grant_take && (grant_id == OWN_IFU);
  assign lsu_req_ready = rst && grant_take && (grant_id == OWN_LSU);

  assign rsp_route     = (state_q == ST_WAIT_RSP) && mem_rsp_valid;
  assign ifu_rsp_valid = rsp_route && (pl_q.owner == OWN_IFU);
  assign lsu_rsp_valid = rsp_route && (pl_q.owner == OWN_LSU);
  assign ifu_rdata     = ifu_rsp_valid ? mem_rdata : '0;
  assign lsu_rdata     = lsu_rsp_valid ? mem_rdata : '0;

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = pl_q.addr;
  assign mem_wen       = pl_q.wen;
  assign mem_wdata     = pl_q.wdata;
  assign mem_wmask     = pl_q.wmask;

  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_ysyx_22050039_mem_arbiter.sv
// Self-checking bench for ysyx_22050039_mem_arbiter: table of single-requester
// transactions plus hand-written tie, fairness, spurious and reset sequences.
module tb_ysyx_22050039_mem_arbiter;
  import ysyx_22050039_mem_pkg::*;

  localparam int XLEN   = 64;
  localparam int MASK_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [XLEN-1:0]   ifu_addr, ifu_rdata;
  logic              lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [XLEN-1:0]   lsu_addr, lsu_wdata, lsu_rdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              busy, err;

  always #5 clk = ~clk;

  ysyx_22050039_mem_arbiter #(.XLEN(XLEN), .MASK_W(MASK_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Memory contents seen by loads; stores are acknowledged with rdata 0.
  function automatic logic [63:0] model_rdata(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h413;
    return {a[31:0] ^ 32'h5a5a_0000, ~a[31:0]};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        owner;
    logic [63:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  logic grant_log[$];
  exp_t mon_e;

  task automatic push_exp(input logic owner, input logic [63:0] rd);
    exp_t e;
    e.owner = owner;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (ifu_req_ready || lsu_req_ready) begin
      check("ready_exclusive", 64'(ifu_req_ready && lsu_req_ready), 64'(0));
      grant_log.push_back(lsu_req_ready);
    end
    if (ifu_rsp_valid || lsu_rsp_valid) begin
      check("rsp_expected", 64'(exp_q.size() > 0), 64'(1));
      check("rsp_one_hot", 64'(ifu_rsp_valid && lsu_rsp_valid), 64'(0));
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("rsp_owner", 64'(lsu_rsp_valid), 64'(mon_e.owner));
        check("rsp_rdata", lsu_rsp_valid ? lsu_rdata : ifu_rdata, mon_e.rdata);
        check("rsp_other_rdata", lsu_rsp_valid ? ifu_rdata : lsu_rdata, 64'(0));
      end
    end
  end

  // ---------------- memory model ----------------
  logic        auto_mem;
  logic        acc;
  logic [63:0] acc_rd;
  int          stall_left;

  initial begin
    acc    = 1'b0;
    acc_rd = '0;
    forever begin
      @(negedge clk);
      acc    = auto_mem && mem_req_valid && mem_req_ready;
      acc_rd = mem_wen ? 64'd0 : model_rdata(mem_addr);
      if (auto_mem && mem_req_valid && !mem_req_ready && stall_left > 0) stall_left--;
      @(posedge clk);
      #1;
      if (auto_mem) begin
        mem_rsp_valid = acc;
        mem_rdata     = acc ? acc_rd : 64'd0;
        mem_req_ready = (stall_left == 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  typedef struct {
    logic        lsu;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          stall;
    logic        poke;
    logic        exp_wen;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  // One transaction from one requester; the LSU bus always carries v's payload
  // so an IFU grant must still show wen=0/wmask=0 on the memory port.
  task automatic run_single(input int idx, input vec_t v);
    stall_left = v.stall;
    tick();
    ifu_addr  = v.addr;
    lsu_addr  = v.addr;
    lsu_wen   = v.wen;
    lsu_wdata = v.wdata;
    lsu_wmask = v.wmask;
    if (v.lsu) lsu_req_valid = 1'b1;
    else       ifu_req_valid = 1'b1;
    push_exp(v.lsu, v.exp_rdata);
    settle();
    check($sformatf("v%0d_ready_own", idx), 64'(v.lsu ? lsu_req_ready : ifu_req_ready), 64'(1));
    check($sformatf("v%0d_ready_other", idx), 64'(v.lsu ? ifu_req_ready : lsu_req_ready), 64'(0));
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    ifu_addr  = ~v.addr;
    lsu_addr  = ~v.addr;
    lsu_wdata = ~v.wdata;
    lsu_wmask = ~v.wmask;
    lsu_wen   = ~v.wen;
    if (v.poke) begin
      if (v.lsu) ifu_req_valid = 1'b1;
      else       lsu_req_valid = 1'b1;
    end
    settle();
    for (int c = 0; c <= v.stall; c++) begin
      check($sformatf("v%0d_req_valid_c%0d", idx, c), 64'(mem_req_valid), 64'(1));
      check($sformatf("v%0d_addr_c%0d", idx, c), mem_addr, v.addr);
      check($sformatf("v%0d_wen_c%0d", idx, c), 64'(mem_wen), 64'(v.exp_wen));
      check($sformatf("v%0d_wmask_c%0d", idx, c), 64'(mem_wmask), 64'(v.exp_wmask));
      if (v.lsu) check($sformatf("v%0d_wdata_c%0d", idx, c), mem_wdata, v.wdata);
      check($sformatf("v%0d_no_ready_c%0d", idx, c), 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
      tick();
      settle();
    end
    check($sformatf("v%0d_wait_req_valid", idx), 64'(mem_req_valid), 64'(0));
    check($sformatf("v%0d_wait_busy", idx), 64'(busy), 64'(1));
    check($sformatf("v%0d_wait_rsp", idx), 64'({ifu_rsp_valid, lsu_rsp_valid}),
          v.lsu ? 64'(2'b01) : 64'(2'b10));
    check($sformatf("v%0d_wait_no_ready", idx), 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick();
    settle();
    check($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    settle();
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_err", 64'(err), 64'(0));
    tick();
    rst = 1'b1;
    tick();
  endtask

  // ---------------- main test ----------------
  initial begin
    // fields: lsu, addr, wen, wdata, wmask, stall, poke, exp_wen, exp_wmask, exp_rdata
    vecs[0] = '{1'b0, 64'h8000_0000, 1'b1, 64'h55, 8'hff, 0, 1'b0, 1'b0, 8'h00, 64'h413};
    vecs[1] = '{1'b1, 64'h8000_0100, 1'b0, 64'h0, 8'hff, 0, 1'b0, 1'b0, 8'hff,
                model_rdata(64'h8000_0100)};
    vecs[2] = '{1'b1, 64'h8000_2000, 1'b1, 64'h1122_3344_5566_7788, 8'hf0, 0, 1'b0,
                1'b1, 8'hf0, 64'h0};
    vecs[3] = '{1'b1, 64'h8000_3000, 1'b1, 64'hcafe_f00d_0bad_beef, 8'hff, 4, 1'b1,
                1'b1, 8'hff, 64'h0};
    vecs[4] = '{1'b0, 64'h8000_0008, 1'b1, 64'h77, 8'h3c, 2, 1'b1, 1'b0, 8'h00,
                model_rdata(64'h8000_0008)};
    vecs[5] = '{1'b0, 64'h8000_0018, 1'b0, 64'h0, 8'h00, 0, 1'b0, 1'b0, 8'h00,
                model_rdata(64'h8000_0018)};

    auto_mem      = 1'b1;
    stall_left    = 0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    ifu_addr  = 64'h8000_0000;
    lsu_addr  = 64'h8000_1000;
    lsu_wen   = 1'b0;
    lsu_wdata = '0;
    lsu_wmask = '0;

    // Reset with both requesters asserting: nothing may be accepted.
    #1 rst = 1'b0;
    #2;
    check("rst_ifu_ready", 64'(ifu_req_ready), 64'(0));
    check("rst_lsu_ready", 64'(lsu_req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
    check("rst_mem_addr", mem_addr, 64'(0));
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_single(i, vecs[i]);
    check("err_clean_after_table", 64'(err), 64'(0));

    // Tie straight after reset: IFU first, then the LSU store.
    do_reset();
    ifu_addr      = 64'h8000_0004;
    lsu_addr      = 64'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 64'hdead_beef;
    lsu_wmask     = 8'h0f;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    push_exp(OWN_IFU, model_rdata(64'h8000_0004));
    settle();
    check("tie_ifu_ready", 64'(ifu_req_ready), 64'(1));
    check("tie_lsu_ready", 64'(lsu_req_ready), 64'(0));
    tick();
    ifu_req_valid = 1'b0;
    settle();
    check("tie_ifu_mem_addr", mem_addr, 64'h8000_0004);
    check("tie_ifu_mem_wen", 64'(mem_wen), 64'(0));
    check("tie_lsu_blocked_req", 64'(lsu_req_ready), 64'(0));
    tick();
    settle();
    check("tie_ifu_rsp", 64'(ifu_rsp_valid), 64'(1));
    check("tie_lsu_blocked_wait", 64'(lsu_req_ready), 64'(0));
    tick();
    push_exp(OWN_LSU, 64'h0);
    settle();
    check("tie_lsu_ready", 64'(lsu_req_ready), 64'(1));
    tick();
    lsu_req_valid = 1'b0;
    settle();
    check("tie_lsu_mem_valid", 64'(mem_req_valid), 64'(1));
    check("tie_lsu_mem_addr", mem_addr, 64'h8000_1000);
    check("tie_lsu_mem_wen", 64'(mem_wen), 64'(1));
    check("tie_lsu_mem_wmask", 64'(mem_wmask), 64'h0f);
    check("tie_lsu_mem_wdata", mem_wdata, 64'hdead_beef);
    tick();
    settle();
    check("tie_lsu_ack", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(2'b01));
    tick();
    settle();
    check("tie_idle", 64'(busy), 64'(0));

    // Fairness: both held valid for 12 cycles -> IFU, LSU, IFU, LSU.
    grant_log.delete();
    ifu_addr  = 64'h8000_0020;
    lsu_addr  = 64'h8000_1008;
    lsu_wen   = 1'b0;
    lsu_wmask = 8'hff;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 1) push_exp(OWN_LSU, model_rdata(64'h8000_1008));
      else            push_exp(OWN_IFU, model_rdata(64'h8000_0020));
    end
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    repeat (12) tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    settle();
    check("fair_grant_count", 64'(grant_log.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < grant_log.size())
        check($sformatf("fair_grant_%0d", k), 64'(grant_log[k]), 64'(k % 2));
    end
    tick();
    tick();
    check("fair_drained", 64'(exp_q.size()), 64'(0));

    // Spurious response in IDLE.
    auto_mem      = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h1234;
    settle();
    check("spur_no_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
    check("spur_err_before_edge", 64'(err), 64'(0));
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    check("spur_err_set", 64'(err), 64'(1));
    check("spur_stays_idle", 64'(busy), 64'(0));
    repeat (3) tick();
    settle();
    check("spur_err_sticky", 64'(err), 64'(1));

    // Reset mid-transaction, with a spurious response seen in REQ first.
    do_reset();
    check("mid_err_cleared", 64'(err), 64'(0));
    ifu_addr      = 64'h8000_0010;
    ifu_req_valid = 1'b1;
    settle();
    check("mid_grant", 64'(ifu_req_ready), 64'(1));
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    settle();
    check("mid_req_spur_no_rsp", 64'(ifu_rsp_valid), 64'(0));
    tick();
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    check("mid_req_spur_err", 64'(err), 64'(1));
    check("mid_still_req", 64'(mem_req_valid), 64'(1));
    tick();
    mem_req_ready = 1'b0;
    settle();
    check("mid_wait_busy", 64'(busy), 64'(1));
    check("mid_wait_no_req", 64'(mem_req_valid), 64'(0));
    #1 rst = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_req_valid", 64'(mem_req_valid), 64'(0));
    check("mid_rst_err", 64'(err), 64'(0));
    tick();
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h5555;
    settle();
    check("mid_late_rsp_dropped", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
    tick();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    mem_req_ready = 1'b1;
    auto_mem      = 1'b1;
    settle();
    check("mid_late_rsp_err", 64'(err), 64'(1));
    run_single(5, vecs[5]);
    check("mid_err_kept", 64'(err), 64'(1));

    tick();
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
